// File: rtl/fsqrt_issue_ctrl.sv
// Issue/return controller around a combinational fsqrt core: operand queue, registered
// core operand, fixed-latency result pipe with exception override, and credit-gated result queue.
module fsqrt_issue_ctrl #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned OQ_DEPTH = 4,
  parameter int unsigned LAT      = 2,
  parameter int unsigned TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      core_x,
  input  logic [31:0]      core_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exc,
  output logic             busy
);

  localparam int unsigned IAW  = $clog2(IQ_DEPTH);
  localparam int unsigned OAW  = $clog2(OQ_DEPTH);
  localparam int unsigned CW   = $clog2(OQ_DEPTH + LAT + 1) + 1;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      x;
  } op_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             exc;
    logic [31:0]      y;
  } res_t;

  // ---------------- input operand queue ----------------
  op_t          iq_mem [IQ_DEPTH];
  logic [IAW:0] iq_wr;
  logic [IAW:0] iq_rd;
  logic         iq_empty;
  logic         iq_full;
  logic         iq_push;
  op_t          iq_head;

  assign iq_empty = (iq_wr == iq_rd);
  assign iq_full  = (iq_wr[IAW] != iq_rd[IAW]) && (iq_wr[IAW-1:0] == iq_rd[IAW-1:0]);
  assign in_ready = !rst && !iq_full;
  assign iq_push  = in_valid && in_ready;
  assign iq_head  = iq_mem[iq_rd[IAW-1:0]];

  always_ff @(posedge clk) begin
    if (iq_push) iq_mem[iq_wr[IAW-1:0]] <= {in_tag, in_x};
  end

  // ---------------- credit check and issue stage ----------------
  logic [OAW:0]     oq_wr;
  logic [OAW:0]     oq_rd;
  logic [OAW:0]     oq_count;
  logic [CW-1:0]    inflight;
  logic             issue;
  logic             s0_valid;
  logic [TAG_W-1:0] s0_tag;

  assign oq_count = oq_wr - oq_rd;
  // A pop this cycle frees its slot only from the next cycle on.
  assign issue    = !iq_empty && ((CW'(oq_count) + inflight) < CW'(OQ_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      iq_wr    <= '0;
      iq_rd    <= '0;
      core_x   <= '0;
      s0_valid <= 1'b0;
      s0_tag   <= '0;
    end else begin
      s0_valid <= issue;
      if (iq_push) iq_wr <= iq_wr + (IAW+1)'(1);
      if (issue) begin
        iq_rd  <= iq_rd + (IAW+1)'(1);
        core_x <= iq_head.x;
        s0_tag <= iq_head.tag;
      end
    end
  end

  // ---------------- result capture and exception override ----------------
  res_t r1;
  logic oq_push;
  res_t oq_wdata;

  always_comb begin
    r1.tag = s0_tag;
    r1.exc = (core_x[31] && (core_x[30:0] != 31'd0)) ||
             ((core_x[30:23] == 8'hFF) && (core_x[22:0] != 23'd0));
    r1.y   = r1.exc ? QNAN : core_y;
  end

  generate
    if (LAT == 1) begin : g_lat1
      assign oq_push  = s0_valid;
      assign oq_wdata = r1;
      assign inflight = CW'(s0_valid);
    end else if (LAT == 2) begin : g_lat2
      logic pv;
      res_t pr;

      always_ff @(posedge clk) begin
        if (rst) pv <= 1'b0;
        else     pv <= s0_valid;
      end

      always_ff @(posedge clk) begin
        pr <= r1;
      end

      assign oq_push  = pv;
      assign oq_wdata = pr;
      assign inflight = CW'(s0_valid) + CW'(pv);
    end else begin : g_latn
      logic [LAT-1:1] pv;
      res_t [LAT-1:1] pr;

      always_ff @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[LAT-2:1], s0_valid};
      end

      always_ff @(posedge clk) begin
        pr <= {pr[LAT-2:1], r1};
      end

      assign oq_push  = pv[LAT-1];
      assign oq_wdata = pr[LAT-1];
      assign inflight = CW'(s0_valid) + CW'($countones(pv));
    end
  endgenerate

  // ---------------- output result queue ----------------
  res_t oq_mem [OQ_DEPTH];
  logic oq_empty;
  logic oq_full;
  logic oq_pop;
  res_t oq_head;

  assign oq_empty = (oq_wr == oq_rd);
  assign oq_full  = (oq_wr[OAW] != oq_rd[OAW]) && (oq_wr[OAW-1:0] == oq_rd[OAW-1:0]);
  assign oq_pop   = out_valid && out_ready;
  assign oq_head  = oq_mem[oq_rd[OAW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      oq_wr <= '0;
      oq_rd <= '0;
      for (int i = 0; i < int'(OQ_DEPTH); i++) oq_mem[i] <= '0;
    end else begin
      assert (!(oq_push && oq_full));
      if (oq_push) begin
        oq_mem[oq_wr[OAW-1:0]] <= oq_wdata;
        oq_wr <= oq_wr + (OAW+1)'(1);
      end
      if (oq_pop) oq_rd <= oq_rd + (OAW+1)'(1);
    end
  end

  assign out_valid = !oq_empty;
  assign out_y     = oq_head.y;
  assign out_tag   = oq_head.tag;
  assign out_exc   = oq_head.exc;
  assign busy      = !iq_empty || (inflight != '0) || !oq_empty;

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Directed + randomized bench for fsqrt_issue_ctrl; provides a behavioural fsqrt core
// and checks results against a FIFO-of-accepted-operands reference.
module tb_fsqrt_issue_ctrl;

  localparam int unsigned TAG_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      core_x;
  logic [31:0]      core_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_exc;
  logic             busy;

  fsqrt_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_tag   (in_tag),
    .core_x   (core_x),
    .core_y   (core_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_tag  (out_tag),
    .out_exc  (out_exc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      x;
  } ent_t;

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_acc = 0;

  // Real-arithmetic square root, truncated to single precision (<1 ulp).
  // Invalid inputs return a NaN different from the canonical one.
  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    real         v;
    real         r;
    logic [63:0] d;
    if (x[30:0] == 31'd0 || x == 32'h7F800000) return x;
    if (x[31] || x[30:23] == 8'hFF) return 32'hFFC00000;
    if (x[30:23] == 8'd0) v = real'(x[22:0]) * $bitstoreal(64'h36A0000000000000);
    else v = $bitstoreal({1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
    r = $sqrt(v);
    d = $realtobits(r);
    return {1'b0, 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic is_exc(input logic [31:0] x);
    logic is_nan;
    logic is_neg;
    is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    is_neg = x[31] && (x[30:0] != 31'd0);
    return is_nan || is_neg;
  endfunction

  function automatic logic [31:0] exp_y(input logic [31:0] x);
    return is_exc(x) ? 32'h7FC00000 : ref_sqrt(x);
  endfunction

  function automatic logic [31:0] t3x(input int i);
    return 32'h40000000 + (32'(i) << 18);
  endfunction

  always_comb core_y = ref_sqrt(core_x);

  task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", name, obs, exp);
    end
  endtask

  // Drive inputs for the next rising edge, score the visible head, then advance to the next falling edge.
  task automatic tick(input logic v, input logic [31:0] x, input logic [TAG_W-1:0] t, input logic r);
    ent_t e;
    in_valid  = v;
    in_x      = x;
    in_tag    = t;
    out_ready = r;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk1("out_valid_no_pending", out_valid, 1'b0);
      end else begin
        e = exp_q[0];
        chk32("out_y", out_y, exp_y(e.x));
        chk32("out_tag", 32'(out_tag), 32'(e.tag));
        chk1("out_exc", out_exc, is_exc(e.x));
        if (r) e = exp_q.pop_front();
      end
    end
    if (v && in_ready) begin
      exp_q.push_back('{tag: t, x: x});
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && (exp_q.size() != 0 || busy); c++) tick(1'b0, 32'd0, '0, 1'b1);
    chk32({name, "_left"}, 32'(exp_q.size()), 32'd0);
    chk1({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] t2_x [4];
    logic [31:0] t2_y [4];
    logic        t2_e [4];
    logic [31:0] spec [6];
    logic [31:0] rx;
    logic [31:0] a_x [5];
    int          base;
    int          hi;

    t2_x = '{32'hBF800000, 32'h80000000, 32'h7FC00001, 32'h7F800000};
    t2_y = '{32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'h7F800000};
    t2_e = '{1'b1, 1'b0, 1'b1, 1'b0};
    spec = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h00000001};
    a_x  = '{32'h41100000, 32'h41800000, 32'h41C80000, 32'h42100000, 32'h42440000};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_y", out_y, 32'd0);
    chk32("rst_out_tag", 32'(out_tag), 32'd0);
    chk1("rst_out_exc", out_exc, 1'b0);
    chk32("rst_core_x", core_x, 32'd0);
    chk1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);

    // Single op: sqrt(4.0), latency check
    tick(1'b1, 32'h40800000, 4'd3, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      chk1("t1_early_valid", out_valid, 1'b0);
      tick(1'b0, 32'd0, '0, 1'b1);
    end
    chk1("t1_valid", out_valid, 1'b1);
    chk32("t1_y", out_y, 32'h40000000);
    chk32("t1_tag", 32'(out_tag), 32'd3);
    chk1("t1_exc", out_exc, 1'b0);
    chk1("t1_busy", busy, 1'b1);
    tick(1'b0, 32'd0, '0, 1'b1);
    chk1("t1_busy_after_pop", busy, 1'b0);
    chk1("t1_valid_after_pop", out_valid, 1'b0);

    // Back-to-back special operands
    for (int i = 0; i < 4; i++) tick(1'b1, t2_x[i], 4'(4 + i), 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("t2_consecutive", out_valid, 1'b1);
      chk32("t2_y", out_y, t2_y[i]);
      chk1("t2_exc", out_exc, t2_e[i]);
      tick(1'b0, 32'd0, '0, 1'b1);
    end
    chk1("t2_done", out_valid, 1'b0);

    // Backpressure: only IQ_DEPTH+OQ_DEPTH accepted while stalled
    base = n_acc;
    hi = 0;
    for (int c = 0; c < 20; c++) begin
      if (c >= 12 && in_ready) hi++;
      tick(1'b1, t3x(n_acc - base), 4'(n_acc - base), 1'b0);
    end
    chk32("t3_accepted", 32'(n_acc - base), 32'd8);
    chk32("t3_ready_high", 32'(hi), 32'd0);
    chk1("t3_in_ready", in_ready, 1'b0);
    for (int c = 0; c < 80 && ((n_acc - base) < 12 || exp_q.size() != 0); c++)
      tick((n_acc - base) < 12, t3x(n_acc - base), 4'(n_acc - base), 1'b1);
    chk32("t3_total", 32'(n_acc - base), 32'd12);
    drain("t3");

    // Randomized traffic
    base = n_acc;
    for (int c = 0; c < 20000 && (n_acc - base) < 2000; c++) begin
      case ($urandom_range(0, 7))
        0:       rx = spec[$urandom_range(0, 5)];
        1:       rx = $urandom | 32'h80000000;
        default: rx = $urandom & 32'h7FFFFFFF;
      endcase
      tick($urandom_range(0, 3) != 0, rx, 4'(n_acc), $urandom_range(0, 3) != 0);
    end
    chk32("t4_accepted", 32'(n_acc - base), 32'd2000);
    drain("t4");

    // Reset with work in every stage
    for (int c = 0; c < 12; c++) tick(1'b1, 32'h40400000 + 32'(c), 4'(c), 1'b0);
    tick(1'b0, 32'd0, '0, 1'b1);
    tick(1'b0, 32'd0, '0, 1'b1);
    tick(1'b1, 32'h40A00000, 4'd13, 1'b0);
    chk1("t5_busy_pre", busy, 1'b1);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk1("t5_ready_in_rst", in_ready, 1'b0);
    chk1("t5_valid_in_rst", out_valid, 1'b0);
    chk1("t5_busy_in_rst", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("t5_in_ready", in_ready, 1'b1);
    chk1("t5_out_valid", out_valid, 1'b0);
    chk1("t5_busy", busy, 1'b0);
    tick(1'b1, 32'h3F800000, 4'd7, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, '0, 1'b1);
    chk1("t5_valid", out_valid, 1'b1);
    chk32("t5_y", out_y, 32'h3F800000);
    chk32("t5_tag", 32'(out_tag), 32'd7);
    drain("t5");

    // Exactly-full credit with a same-cycle pop
    for (int i = 0; i < 5; i++) tick(1'b1, a_x[i], 4'(i), 1'b0);
    chk32("t6_core_x_d", core_x, a_x[3]);
    tick(1'b0, 32'd0, '0, 1'b0);
    chk32("t6_core_x_hold", core_x, a_x[3]);
    tick(1'b0, 32'd0, '0, 1'b1);
    chk32("t6_no_issue", core_x, a_x[3]);
    tick(1'b0, 32'd0, '0, 1'b0);
    chk32("t6_issue_next", core_x, a_x[4]);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
